bus_regbank: RTL and testbench
==============================

BUS_REGBANK -- requirements
Module: bus_regbank

Interface
REQ-001 Parameter WIDTH, default 32, bit width of the bus, every register and the MDR.
REQ-002 Parameter NREG, default 16, number of general registers (2..32).
REQ-003 Parameter TIMEOUT, default 15, maximum cycles spent waiting for mem_ack (1..255).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 clr  input  1  reset, asynchronous, active-high.
REQ-006 reg_out  input  NREG  per-register bus drive request, one-hot intended.
REQ-007 mdr_out  input  1  MDR bus drive request.
REQ-008 ext_out  input  1  external-data bus drive request.
REQ-009 ext_data  input  WIDTH  external value driven onto the bus when selected.
REQ-010 reg_in  input  NREG  per-register load enable from the bus.
REQ-011 mdr_in  input  1  MDR load enable from the bus.
REQ-012 rd_start  input  1  start a memory read into the MDR.
REQ-013 mem_req  output  1  memory read request.
REQ-014 mem_ack  input  1  memory read data valid.
REQ-015 mem_rdata  input  WIDTH  memory read data.
REQ-016 mdr_busy  output  1  memory read in progress.
REQ-017 mdr_done  output  1  one-cycle pulse when a read completes.
REQ-018 mem_err  output  1  sticky read timeout flag.
REQ-019 bus_conflict  output  1  sticky multiple-driver flag.
REQ-020 flag_clr  input  1  clears mem_err and bus_conflict.
REQ-021 bus  output  WIDTH  current bus contents (combinational).
REQ-022 dbg_sel  input  clog2(NREG)  debug register index.
REQ-023 dbg_q  output  WIDTH  contents of register dbg_sel (combinational).

Function
REQ-024 bus SHALL equal the lowest-index asserted source in order reg 0..NREG-1, MDR, ext; 0 when no source asserted.
REQ-025 More than one asserted source in a cycle SHALL set bus_conflict at the next edge; set wins over a simultaneous flag_clr.
REQ-026 Each register k with reg_in[k]=1 SHALL load bus at the edge; multiple simultaneous loads (broadcast) permitted; reg_out[k] and reg_in[k] together holds the value.
REQ-027 MDR FSM states IDLE, WAIT, DONE; mem_req=1 and mdr_busy=1 only in WAIT; mdr_done=1 only in DONE.
REQ-028 IDLE: rd_start -> WAIT, timeout counter cleared; else mdr_in loads MDR from bus.
REQ-029 WAIT: mem_ack -> MDR captures mem_rdata, -> DONE; counter reaching TIMEOUT without ack -> IDLE, mem_err set, MDR unchanged.
REQ-030 DONE: rd_start -> WAIT (back-to-back read); else -> IDLE.
REQ-031 mdr_in SHALL be ignored in WAIT and DONE; rd_start ignored in WAIT; mem_ack ignored outside WAIT.
REQ-032 The MDR SHALL drive its old value onto the bus until the capture edge; minimum read latency rd_start to mdr_done is 2 cycles with immediate ack.
REQ-033 dbg_sel >= NREG SHALL yield dbg_q = 0.

Reset
REQ-034 clr=1 SHALL immediately force all registers and MDR to 0, FSM to IDLE, counter to 0, mem_req, mdr_busy, mdr_done, mem_err, bus_conflict to 0.
REQ-035 clr asserted during WAIT SHALL abandon the read; no capture after clr deasserts.

Configuration
REQ-036 Macro BUS_REGBANK_R0_ZERO_EN defined: register 0 SHALL read 0 on bus and dbg_q, reg_in[0] discarded; undefined: register 0 is an ordinary register.

Verification
REQ-037 ext_data=0xDEADBEEF, ext_out=1, reg_in[3]=1 one cycle; then reg_out[3]=1 -> bus=0xDEADBEEF, bus_conflict=0.
REQ-038 reg_out[2]=1 and mdr_out=1 same cycle -> bus=R2 value, bus_conflict=1 next edge, stays 1 until flag_clr.
REQ-039 rd_start pulse, mem_ack with mem_rdata=0x12345678 two cycles later -> mem_req high 2 cycles, MDR=0x12345678, mdr_done one-cycle pulse.
REQ-040 rd_start with mem_ack never asserted, TIMEOUT=15 -> mem_req drops after 15 WAIT cycles, mem_err=1, MDR unchanged.
REQ-041 clr pulsed mid-WAIT, mem_ack after clr release -> MDR=0, FSM IDLE, mem_req=0.
REQ-042 With BUS_REGBANK_R0_ZERO_EN: ext_data=0xFFFFFFFF loaded to reg 0, reg_out[0]=1 -> bus=0; without macro -> bus=0xFFFFFFFF.

Source files
------------

// File: rtl/bus_regbank_if.sv
// Bus, register-select and memory-read handshake signals of bus_regbank.
// The master side drives the controls; the slave side is the register bank.
interface bus_regbank_if #(
  parameter int WIDTH = 32,
  parameter int NREG  = 16
);
  localparam int SELW = $clog2(NREG);

  logic [NREG-1:0]  reg_out;
  logic             mdr_out;
  logic             ext_out;
  logic [WIDTH-1:0] ext_data;
  logic [NREG-1:0]  reg_in;
  logic             mdr_in;
  logic             rd_start;
  logic             mem_req;
  logic             mem_ack;
  logic [WIDTH-1:0] mem_rdata;
  logic             mdr_busy;
  logic             mdr_done;
  logic             mem_err;
  logic             bus_conflict;
  logic             flag_clr;
  logic [WIDTH-1:0] bus;
  logic [SELW-1:0]  dbg_sel;
  logic [WIDTH-1:0] dbg_q;

  modport master (
    output reg_out, mdr_out, ext_out, ext_data, reg_in, mdr_in, rd_start,
           mem_ack, mem_rdata, flag_clr, dbg_sel,
    input  mem_req, mdr_busy, mdr_done, mem_err, bus_conflict, bus, dbg_q
  );

  modport slave (
    input  reg_out, mdr_out, ext_out, ext_data, reg_in, mdr_in, rd_start,
           mem_ack, mem_rdata, flag_clr, dbg_sel,
    output mem_req, mdr_busy, mdr_done, mem_err, bus_conflict, bus, dbg_q
  );
endinterface

// File: rtl/bus_regbank.sv
// Shared-bus register bank with an MDR that can be filled by a timed memory read.
// Define BUS_REGBANK_R0_ZERO_EN to make register 0 a hard-wired zero.
module bus_regbank #(
  parameter int WIDTH   = 32,
  parameter int NREG    = 16,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          clr,
  bus_regbank_if.slave  bif
);

`ifdef BUS_REGBANK_R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  localparam int         SELW    = $clog2(NREG);
  localparam int         NSRC    = NREG + 2;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  logic [WIDTH-1:0] r_regs [NREG];
  logic [WIDTH-1:0] r_mdr;
  state_t           r_state;
  logic [7:0]       r_cnt;
  logic             r_mem_req;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic             r_conflict;

  logic [WIDTH-1:0] w_view [NREG];
  logic [WIDTH-1:0] w_bus;
  logic [WIDTH-1:0] w_dbg;
  logic [NSRC-1:0]  w_src;
  logic             w_multi;
  logic             w_timeout;

  always_comb begin
    for (int k = 0; k < NREG; k++) begin
      w_view[k] = (R0_ZERO && k == 0) ? '0 : r_regs[k];
    end
  end

  // Lowest-index source wins: later assignments override earlier ones.
  always_comb begin
    w_bus = '0;
    if (bif.ext_out) w_bus = bif.ext_data;
    if (bif.mdr_out) w_bus = r_mdr;
    for (int k = NREG - 1; k >= 0; k--) begin
      if (bif.reg_out[k]) w_bus = w_view[k];
    end
  end

  assign w_src   = {bif.ext_out, bif.mdr_out, bif.reg_out};
  assign w_multi = (w_src & (w_src - NSRC'(1))) != '0;

  always_comb begin
    w_dbg = '0;
    for (int k = 0; k < NREG; k++) begin
      if (bif.dbg_sel == SELW'(k)) w_dbg = w_view[k];
    end
  end

  // A register that both drives and loads keeps its value.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int k = 0; k < NREG; k++) r_regs[k] <= '0;
    end else begin
      for (int k = 0; k < NREG; k++) begin
        if (bif.reg_in[k] && !bif.reg_out[k] && !(R0_ZERO && k == 0))
          r_regs[k] <= w_bus;
      end
    end
  end

  assign w_timeout = (r_state == S_WAIT) && !bif.mem_ack && (r_cnt == TO_LAST);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_mem_req <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_mdr     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bif.rd_start) begin
            r_state   <= S_WAIT;
            r_cnt     <= '0;
            r_mem_req <= 1'b1;
            r_busy    <= 1'b1;
          end else if (bif.mdr_in) begin
            r_mdr <= w_bus;
          end
        end
        S_WAIT: begin
          if (bif.mem_ack) begin
            r_mdr     <= bif.mem_rdata;
            r_state   <= S_DONE;
            r_mem_req <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
          end else if (w_timeout) begin
            r_state   <= S_IDLE;
            r_mem_req <= 1'b0;
            r_busy    <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_DONE: begin
          if (bif.rd_start) begin
            r_state   <= S_WAIT;
            r_cnt     <= '0;
            r_mem_req <= 1'b1;
            r_busy    <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_mem_req <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  // Sticky flags: a new set event takes priority over flag_clr.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_err      <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      r_err      <= w_timeout | (r_err & ~bif.flag_clr);
      r_conflict <= w_multi | (r_conflict & ~bif.flag_clr);
    end
  end

  assign bif.bus          = w_bus;
  assign bif.dbg_q        = w_dbg;
  assign bif.mem_req      = r_mem_req;
  assign bif.mdr_busy     = r_busy;
  assign bif.mdr_done     = r_done;
  assign bif.mem_err      = r_err;
  assign bif.bus_conflict = r_conflict;

endmodule

// File: tb/tb_bus_regbank.sv
// Self-checking bench for bus_regbank: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a model.
module tb_bus_regbank;
  localparam int WIDTH   = 32;
  localparam int NREG    = 12;
  localparam int TIMEOUT = 15;

`ifdef BUS_REGBANK_R0_ZERO_EN
  localparam bit R0Z = 1'b1;
`else
  localparam bit R0Z = 1'b0;
`endif

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  bus_regbank_if #(.WIDTH(WIDTH), .NREG(NREG)) bif ();

  bus_regbank #(.WIDTH(WIDTH), .NREG(NREG), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .clr (clr),
    .bif (bif)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: register file contents, MDR, an outstanding read with
  // the number of cycles already waited, the done pulse, and the two flags.
  logic [WIDTH-1:0] m_regs [NREG];
  logic [WIDTH-1:0] m_mdr;
  bit               m_pending, m_done, m_err, m_conf;
  int               m_waited;

  function automatic logic [WIDTH-1:0] m_view(input int k);
    return (R0Z && k == 0) ? '0 : m_regs[k];
  endfunction

  function automatic logic [WIDTH-1:0] m_bus();
    for (int k = 0; k < NREG; k++) if (bif.reg_out[k]) return m_view(k);
    if (bif.mdr_out) return m_mdr;
    if (bif.ext_out) return bif.ext_data;
    return '0;
  endfunction

  function automatic logic [WIDTH-1:0] m_dbg();
    if (int'(bif.dbg_sel) < NREG) return m_view(int'(bif.dbg_sel));
    return '0;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < NREG; k++) m_regs[k] = '0;
    m_mdr = '0; m_pending = 0; m_done = 0; m_err = 0; m_conf = 0; m_waited = 0;
  endtask

  task automatic m_step();
    logic [WIDTH-1:0] b;
    bit multi, tout;
    b     = m_bus();
    multi = $countones({bif.ext_out, bif.mdr_out, bif.reg_out}) > 1;
    tout  = 0;
    for (int k = 0; k < NREG; k++)
      if (bif.reg_in[k] && !bif.reg_out[k] && !(R0Z && k == 0)) m_regs[k] = b;
    if (m_pending) begin
      if (bif.mem_ack) begin
        m_mdr = bif.mem_rdata; m_pending = 0; m_done = 1;
      end else begin
        m_waited++;
        if (m_waited == TIMEOUT) begin m_pending = 0; tout = 1; end
      end
    end else if (m_done) begin
      m_done = 0;
      if (bif.rd_start) begin m_pending = 1; m_waited = 0; end
    end else if (bif.rd_start) begin
      m_pending = 1; m_waited = 0;
    end else if (bif.mdr_in) begin
      m_mdr = b;
    end
    m_conf = multi || (m_conf && !bif.flag_clr);
    m_err  = tout  || (m_err  && !bif.flag_clr);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (clr) m_reset();
      check("m.bus",          bif.bus,          m_bus());
      check("m.dbg_q",        bif.dbg_q,        m_dbg());
      check("m.mem_req",      bif.mem_req,      m_pending);
      check("m.mdr_busy",     bif.mdr_busy,     m_pending);
      check("m.mdr_done",     bif.mdr_done,     m_done);
      check("m.mem_err",      bif.mem_err,      m_err);
      check("m.bus_conflict", bif.bus_conflict, m_conf);
      if (!clr) m_step();
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    bif.reg_out = '0; bif.reg_in = '0; bif.mdr_out = 0; bif.ext_out = 0;
    bif.mdr_in = 0; bif.rd_start = 0; bif.mem_ack = 0; bif.flag_clr = 0;
  endtask

  initial begin
    int hi;
    clr = 1'b0;
    quiet();
    bif.ext_data = '0; bif.mem_rdata = '0; bif.dbg_sel = 4'd3;
    #2 clr = 1'b1;
    cyc(); cyc();
    @(negedge clk);
    check("rst.bus", bif.bus, 32'h0);
    check("rst.mem_req", bif.mem_req, 1'b0);
    check("rst.mdr_done", bif.mdr_done, 1'b0);
    check("rst.mem_err", bif.mem_err, 1'b0);
    check("rst.conflict", bif.bus_conflict, 1'b0);
    check("rst.dbg_q", bif.dbg_q, 32'h0);
    cyc(); clr = 1'b0;

    // External value into R3, then R3 onto the bus.
    cyc(); quiet(); bif.ext_data = 32'hDEADBEEF; bif.ext_out = 1; bif.reg_in[3] = 1;
    cyc(); quiet(); bif.reg_out[3] = 1;
    @(negedge clk);
    check("r3.bus", bif.bus, 32'hDEADBEEF);
    check("r3.dbg_q", bif.dbg_q, 32'hDEADBEEF);
    cyc(); quiet();
    @(negedge clk);
    check("r3.conflict", bif.bus_conflict, 1'b0);

    // Two drivers: R2 wins, conflict sticks until flag_clr.
    cyc(); quiet(); bif.ext_data = 32'hA5A50002; bif.ext_out = 1; bif.reg_in[2] = 1;
    cyc(); quiet(); bif.ext_data = 32'h0BADF00D; bif.ext_out = 1; bif.mdr_in = 1;
    cyc(); quiet(); bif.reg_out[2] = 1; bif.mdr_out = 1;
    @(negedge clk);
    check("cf.bus", bif.bus, 32'hA5A50002);
    check("cf.before", bif.bus_conflict, 1'b0);
    cyc(); quiet();
    @(negedge clk);
    check("cf.set", bif.bus_conflict, 1'b1);
    cyc(); quiet(); bif.mdr_out = 1;
    @(negedge clk);
    check("cf.sticky", bif.bus_conflict, 1'b1);
    check("cf.mdr", bif.bus, 32'h0BADF00D);
    cyc(); quiet(); bif.flag_clr = 1;
    cyc(); quiet();
    @(negedge clk);
    check("cf.cleared", bif.bus_conflict, 1'b0);

    // Memory read with ack two cycles after rd_start.
    cyc(); quiet(); bif.rd_start = 1;
    @(negedge clk);
    check("rd.req0", bif.mem_req, 1'b0);
    cyc(); quiet();
    @(negedge clk);
    check("rd.req1", bif.mem_req, 1'b1);
    check("rd.busy1", bif.mdr_busy, 1'b1);
    cyc(); quiet(); bif.mem_ack = 1; bif.mem_rdata = 32'h12345678;
    @(negedge clk);
    check("rd.req2", bif.mem_req, 1'b1);
    cyc(); quiet(); bif.mem_rdata = '0;
    @(negedge clk);
    check("rd.req3", bif.mem_req, 1'b0);
    check("rd.done", bif.mdr_done, 1'b1);
    cyc(); quiet(); bif.mdr_out = 1;
    @(negedge clk);
    check("rd.done_end", bif.mdr_done, 1'b0);
    check("rd.mdr", bif.bus, 32'h12345678);

    // Read that never gets an ack.
    cyc(); quiet(); bif.rd_start = 1; bif.mem_rdata = 32'hFFFF0000;
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(); quiet();
      @(negedge clk);
      if (bif.mem_req) hi++;
    end
    check("to.req_cycles", hi, 15);
    check("to.mem_err", bif.mem_err, 1'b1);
    cyc(); quiet(); bif.mdr_out = 1;
    @(negedge clk);
    check("to.mdr_kept", bif.bus, 32'h12345678);
    check("to.no_done", bif.mdr_done, 1'b0);
    cyc(); quiet(); bif.flag_clr = 1;
    cyc(); quiet();
    @(negedge clk);
    check("to.err_clr", bif.mem_err, 1'b0);

    // Reset in the middle of a read; a late ack must not be captured.
    cyc(); quiet(); bif.rd_start = 1;
    cyc(); quiet();
    cyc(); quiet();
    @(negedge clk);
    check("cw.req", bif.mem_req, 1'b1);
    cyc(); quiet(); clr = 1'b1;
    @(negedge clk);
    check("cw.req_clr", bif.mem_req, 1'b0);
    check("cw.busy_clr", bif.mdr_busy, 1'b0);
    cyc(); clr = 1'b0; quiet(); bif.mem_ack = 1; bif.mem_rdata = 32'hCAFEF00D;
    cyc(); quiet(); bif.mdr_out = 1; bif.dbg_sel = 4'd3;
    @(negedge clk);
    check("cw.mdr", bif.bus, 32'h0);
    check("cw.done", bif.mdr_done, 1'b0);
    check("cw.req_after", bif.mem_req, 1'b0);
    check("cw.r3", bif.dbg_q, 32'h0);

    // Register 0 behaviour.
    cyc(); quiet(); bif.ext_data = 32'hFFFFFFFF; bif.ext_out = 1; bif.reg_in[0] = 1;
    bif.dbg_sel = 4'd0;
    cyc(); quiet(); bif.reg_out[0] = 1;
    @(negedge clk);
    check("r0.bus", bif.bus, R0Z ? 32'h0 : 32'hFFFFFFFF);
    check("r0.dbg_q", bif.dbg_q, R0Z ? 32'h0 : 32'hFFFFFFFF);

    // Debug index beyond the register count.
    cyc(); quiet(); bif.ext_data = 32'h11111111; bif.ext_out = 1; bif.reg_in[11] = 1;
    cyc(); quiet(); bif.dbg_sel = 4'd11;
    @(negedge clk);
    check("dbg.r11", bif.dbg_q, 32'h11111111);
    cyc(); quiet(); bif.dbg_sel = 4'd13;
    @(negedge clk);
    check("dbg.oob", bif.dbg_q, 32'h0);

    // Randomized traffic; the compare process checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      int r;
      cyc();
      r = int'($urandom_range(0, 9));
      bif.reg_out = '0;
      if (r >= 9) bif.reg_out = NREG'($urandom);
      else if (r >= 5) bif.reg_out[$urandom_range(0, NREG - 1)] = 1'b1;
      bif.mdr_out   = ($urandom_range(0, 5) == 0);
      bif.ext_out   = ($urandom_range(0, 3) == 0);
      bif.ext_data  = $urandom;
      bif.reg_in    = NREG'($urandom & $urandom);
      bif.mdr_in    = ($urandom_range(0, 3) == 0);
      bif.rd_start  = ($urandom_range(0, 5) == 0);
      bif.mem_ack   = ($urandom_range(0, 7) == 0);
      bif.mem_rdata = $urandom;
      bif.flag_clr  = ($urandom_range(0, 15) == 0);
      bif.dbg_sel   = 4'($urandom_range(0, 15));
      clr           = ($urandom_range(0, 199) == 0);
    end
    cyc(); quiet(); clr = 1'b0;
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
